// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite host master.
// Holds the AXI response codes, the transaction FSM state encoding and the
// default watchdog budget.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_AW_W,
        S_WR_B,
        S_RD_AR,
        S_RD_R,
        S_RESP,
        S_HUNG
    } state_t;

endpackage

// File: rtl/axi_lite_host_master.sv
// Purpose: one-command-at-a-time request/response to AXI4-Lite master with a response watchdog.
// Latency: zero-wait write = accept c0, AW/W c1, B c2, rsp_valid c3; reads likewise via AR/R.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready; a hung slave latches 'hung'.
// Ports: clk/rst (async, active-high); cmd_* request in; rsp_* response out; hung sticky flag;
//        m_axi_aw*/w*/b*/ar*/r* the five AXI4-Lite channels (master side).
module axi_lite_host_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic                    hung,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [WDOG_W-1:0] wdog;

    logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic aw_done, w_done;
    logic in_wait, completing;

    // Gated by rst so the command port reads as not-ready during reset.
    assign cmd_ready = (state == S_IDLE) && !rst;

    assign aw_fire = m_axi_awvalid && m_axi_awready;
    assign w_fire  = m_axi_wvalid  && m_axi_wready;
    assign b_fire  = m_axi_bvalid  && m_axi_bready;
    assign ar_fire = m_axi_arvalid && m_axi_arready;
    assign r_fire  = m_axi_rvalid  && m_axi_rready;

    // In WR_AW_W each valid only drops on its own handshake, so a low
    // valid means that channel already completed.
    assign aw_done = !m_axi_awvalid || aw_fire;
    assign w_done  = !m_axi_wvalid  || w_fire;

    always_comb begin
        in_wait    = 1'b0;
        completing = 1'b0;
        case (state)
            S_WR_AW_W: begin in_wait = 1'b1; completing = aw_done && w_done; end
            S_WR_B:    begin in_wait = 1'b1; completing = b_fire;  end
            S_RD_AR:   begin in_wait = 1'b1; completing = ar_fire; end
            S_RD_R:    begin in_wait = 1'b1; completing = r_fire;  end
            default:   begin in_wait = 1'b0; completing = 1'b0;    end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            wdog          <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            rsp_timeout   <= 1'b0;
            hung          <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else if (in_wait && !completing && wdog == WDOG_LAST) begin
            // Watchdog expiry: abandon the bus transaction and report SLVERR.
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_SLVERR;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= S_RESP;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wdog        <= '0;
                        rsp_timeout <= 1'b0;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= S_WR_AW_W;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= S_RD_AR;
                        end
                    end
                end
                S_WR_AW_W: begin
                    if (aw_fire) m_axi_awvalid <= 1'b0;
                    if (w_fire)  m_axi_wvalid  <= 1'b0;
                    if (completing) begin
                        m_axi_bready <= 1'b1;
                        wdog         <= '0;
                        state        <= S_WR_B;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                S_WR_B: begin
                    if (b_fire) begin
                        m_axi_bready <= 1'b0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                S_RD_AR: begin
                    if (ar_fire) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        wdog          <= '0;
                        state         <= S_RD_R;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                S_RD_R: begin
                    if (r_fire) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_valid    <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_timeout) begin
                            hung  <= 1'b1;
                            state <= S_HUNG;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_HUNG: hung <= 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
